fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_if.sv | 39 +++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types for the instruction fetch unit and its buffer.
// Rev    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int c_XLEN = 32;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_if
// Brief  : PC, instruction-memory and decode handshakes of the fetch unit.
// Rev    : 1.0 - initial release
// ============================================================================
interface fetch_if;
    import fetch_pkg::*;

    logic [c_XLEN-1:0] pc;
    logic              pcread;
    logic              pcenable;
    logic [c_XLEN-1:0] next_pc;
    logic              redirect;
    logic [c_XLEN-1:0] redirect_target;
    logic              imem_req;
    logic [c_XLEN-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [c_XLEN-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [c_XLEN-1:0] inst_data;
    logic [c_XLEN-1:0] inst_pc;

    // master: the fetch unit itself
    modport master (
        input  pc, redirect, redirect_target, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output pcread, pcenable, next_pc, imem_req, imem_addr, inst_valid, inst_data, inst_pc
    );

    // slave: PC block, memory and decode stage
    modport slave (
        output pc, redirect, redirect_target, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  pcread, pcenable, next_pc, imem_req, imem_addr, inst_valid, inst_data, inst_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Instruction buffer holding {pc, inst} pairs in fetch order.
// Rev    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int              c_PW   = $clog2(DEPTH);
    localparam int              c_CW   = $clog2(DEPTH + 1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : Single-outstanding instruction fetch with redirect handling.
// Rev    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rstn,
    fetch_if.master bus
);

    localparam int              c_CW    = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    fetch_state_t      r_state;
    logic [c_XLEN-1:0] r_req_pc;

    logic [c_CW-1:0]   w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_entry;
    logic              w_req;
    logic              w_accept;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;

    // Every output is gated by rstn so nothing leaks while reset is held.
    always_comb begin
        w_req        = rstn && (r_state == REQ) && (w_count < c_DEPTH) && !bus.redirect;
        w_accept     = w_req && bus.imem_gnt;
        w_valid      = rstn && (w_count != '0) && !bus.redirect;
        w_pop        = w_valid && bus.inst_ready;
        w_push       = rstn && (r_state == WAIT) && bus.imem_rvalid && !bus.redirect;
        w_flush      = rstn && bus.redirect;
        w_push_entry = '{pc: r_req_pc, inst: bus.imem_rdata};
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = rstn ? bus.pc : '0;
    assign bus.pcread    = w_accept;
    assign bus.pcenable  = rstn && bus.redirect;
    assign bus.next_pc   = rstn ? bus.redirect_target : '0;
    assign bus.inst_valid = w_valid;
    assign bus.inst_data  = rstn ? w_head.inst : '0;
    assign bus.inst_pc    = rstn ? w_head.pc   : '0;

    // A redirect with the response still in flight parks in DROP until it lands.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= REQ;
            r_req_pc <= '0;
        end else begin
            case (r_state)
                REQ: begin
                    if (w_accept) begin
                        r_state  <= WAIT;
                        r_req_pc <= bus.pc;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_state <= REQ;
                    end else if (bus.redirect) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid) begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (w_flush),
        .count      (w_count),
        .head       (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Scoreboard bench for fetch_unit with PC and memory models.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    fetch_if bus();

    fetch_unit #(
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // PC register block
    always @(posedge clk) begin
        if (!rstn)             bus.pc <= 32'd0;
        else if (bus.pcenable) bus.pc <= bus.next_pc;
        else if (bus.pcread)   bus.pc <= bus.pc + 32'd4;
    end

    // ---------------- reference model + scoreboard monitor ----------------
    fetch_entry_t exp_q[$];
    logic         busy = 1'b0;
    logic         live = 1'b0;
    logic [31:0]  pend_addr = '0;
    logic [31:0]  popped[$];
    logic [31:0]  grants[$];
    int           n_grants = 0;

    always @(negedge clk) begin
        logic exp_req;
        logic exp_valid;
        exp_req   = rstn && !busy && !bus.redirect && (exp_q.size() < DEPTH);
        exp_valid = rstn && (exp_q.size() != 0) && !bus.redirect;

        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        chk("pcread",   32'(bus.pcread),   32'(exp_req && bus.imem_gnt));
        chk("pcenable", 32'(bus.pcenable), 32'(rstn && bus.redirect));
        chk("next_pc",  bus.next_pc, rstn ? bus.redirect_target : 32'd0);
        chk("inst_valid", 32'(bus.inst_valid), 32'(exp_valid));
        if (!rstn) begin
            chk("rst_imem_addr", bus.imem_addr, 32'd0);
            chk("rst_inst_pc",   bus.inst_pc,   32'd0);
            chk("rst_inst_data", bus.inst_data, 32'd0);
        end else begin
            if (exp_req) chk("imem_addr", bus.imem_addr, bus.pc);
            if (exp_valid) begin
                chk("inst_pc",   bus.inst_pc,   exp_q[0].pc);
                chk("inst_data", bus.inst_data, exp_q[0].inst);
            end
        end

        if (!rstn) begin
            exp_q.delete();
            busy = 1'b0;
            live = 1'b0;
        end else begin
            if (exp_valid && bus.inst_ready) begin
                popped.push_back(exp_q[0].pc);
                void'(exp_q.pop_front());
            end
            if (busy && bus.imem_rvalid) begin
                if (live && !bus.redirect)
                    exp_q.push_back('{pc: pend_addr, inst: memword(pend_addr)});
                busy = 1'b0;
            end else if (exp_req && bus.imem_gnt) begin
                busy      = 1'b1;
                live      = 1'b1;
                pend_addr = bus.pc;
                grants.push_back(bus.pc);
                n_grants++;
            end
            if (bus.redirect) begin
                exp_q.delete();
                live = 1'b0;
            end
        end
    end

    // ---------------- stimulus: memory, decode and redirect source ----------------
    int          gnt_pct = 100, ready_pct = 100, redir_pct = 0, rst_pm = 0;
    int          lat_lo = 1, lat_hi = 1;
    logic        f_redirect = 1'b0, f_reset = 1'b1;
    logic [31:0] f_target = '0;
    logic        mem_pend = 1'b0, accepted = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;
    logic        obs_req = 1'b0;
    logic [31:0] obs_addr = '0, obs_pc = '0;

    task automatic step();
        @(negedge clk);
        accepted = 1'b0;
        obs_req  = bus.imem_req;
        obs_addr = bus.imem_addr;
        obs_pc   = bus.pc;
        if (mem_pend && bus.imem_rvalid) mem_pend = 1'b0;
        if (bus.imem_req && bus.imem_gnt) begin
            mem_pend = 1'b1;
            mem_addr = bus.imem_addr;
            mem_wait = $urandom_range(lat_hi, lat_lo);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (mem_pend) begin
            mem_wait--;
            if (mem_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = memword(mem_addr);
            end
        end
        bus.imem_gnt   = !mem_pend && ($urandom_range(99, 0) < gnt_pct);
        bus.inst_ready = ($urandom_range(99, 0) < ready_pct);
        if (f_redirect) begin
            bus.redirect        = 1'b1;
            bus.redirect_target = f_target;
        end else begin
            bus.redirect        = ($urandom_range(99, 0) < redir_pct);
            bus.redirect_target = $urandom & 32'hFFFF_FFFC;
        end
        rstn = !(f_reset || ($urandom_range(999, 0) < rst_pm));
    endtask

    task automatic wait_accept(input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!accepted && k < 40);
        if (!accepted) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no grant after %0d cycles, expected one", name, k);
        end
    endtask

    task automatic chk_first_grant(input string name, input logic [31:0] exp);
        chk(name, (grants.size() != 0) ? grants[0] : 32'hxxxx_xxxx, exp);
    endtask

    initial begin
        logic [31:0] a0;
        int          g0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;

        // reset held with redirect asserted: everything must stay 0
        f_reset = 1'b1; f_redirect = 1'b1; f_target = 32'h0000_1230;
        repeat (3) step();
        f_redirect = 1'b0;
        f_reset    = 1'b0;

        // streaming fetch from pc 0
        popped.delete();
        repeat (12) step();
        chk("stream_pc0", (popped.size() > 0) ? popped[0] : 32'hxxxx_xxxx, 32'd0);
        chk("stream_pc1", (popped.size() > 1) ? popped[1] : 32'hxxxx_xxxx, 32'd4);
        chk("stream_pc2", (popped.size() > 2) ? popped[2] : 32'hxxxx_xxxx, 32'd8);

        // decode stalled: exactly DEPTH requests, then the buffer is full
        ready_pct = 0;
        g0 = n_grants;
        f_redirect = 1'b1; f_target = 32'h0000_0200;
        step();
        f_redirect = 1'b0;
        repeat (12) step();
        chk("stall_grants", 32'(n_grants - g0), 32'(DEPTH));
        chk("stall_count", 32'(dut.w_count), 32'(DEPTH));
        popped.delete();
        ready_pct = 100;
        repeat (10) step();
        chk("resume_pc0", (popped.size() > 0) ? popped[0] : 32'hxxxx_xxxx, 32'h200);
        chk("resume_pc1", (popped.size() > 1) ? popped[1] : 32'hxxxx_xxxx, 32'h204);

        // redirect while waiting for a slow response
        lat_lo = 3; lat_hi = 3;
        wait_accept("redir_wait_pre");
        f_redirect = 1'b1; f_target = 32'h0000_0100;
        step();
        f_redirect = 1'b0;
        grants.delete();
        wait_accept("redir_wait_post");
        chk_first_grant("redir_wait_addr", 32'h100);

        // redirect coincident with rvalid
        lat_lo = 2; lat_hi = 2;
        wait_accept("redir_rvalid_pre");
        f_redirect = 1'b1; f_target = 32'h0000_0300;
        step();
        f_redirect = 1'b0;
        grants.delete();
        wait_accept("redir_rvalid_post");
        chk_first_grant("redir_rvalid_addr", 32'h300);

        // redirect coincident with grant: request withdrawn
        lat_lo = 1; lat_hi = 1;
        wait_accept("redir_gnt_pre");
        step();
        f_redirect = 1'b1; f_target = 32'h0000_0400;
        step();
        f_redirect = 1'b0;
        grants.delete();
        wait_accept("redir_gnt_post");
        chk_first_grant("redir_gnt_addr", 32'h400);

        // grant withheld for 5 cycles: request and address hold steady
        gnt_pct = 0;
        repeat (4) step();
        step();
        a0 = obs_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("gntlow_req",  32'(obs_req), 32'd1);
            chk("gntlow_addr", obs_addr, a0);
            chk("gntlow_pc",   obs_pc, a0);
        end
        gnt_pct = 100;
        grants.delete();
        wait_accept("gntlow_post");
        chk_first_grant("gntlow_grant_addr", a0);

        // reset while a response is outstanding; it lands during reset
        lat_lo = 3; lat_hi = 3;
        wait_accept("rst_wait_pre");
        f_reset = 1'b1;
        repeat (3) step();
        f_reset = 1'b0;
        grants.delete();
        wait_accept("rst_wait_post");
        chk_first_grant("rst_restart_addr", 32'd0);

        // randomized traffic
        gnt_pct = 70; ready_pct = 60; redir_pct = 5; rst_pm = 5;
        lat_lo = 1; lat_hi = 3;
        repeat (3000) step();
        rst_pm = 0; redir_pct = 0;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
